rat_int_ctrl: RTL and testbench

RAT_INT_CTRL -- requirements
Module: rat_int_ctrl

---
 rtl/rat_int_pkg.sv | 26 ++
 rtl/rat_prio_enc.sv | 19 +
 rtl/rat_int_ctrl.sv | 140 ++++++++++++++
 tb/tb_rat_int_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_int_pkg.sv
// Shared types and default constants for the rat_int_ctrl interrupt controller.
package rat_int_pkg;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned ID_W    = 3;

  localparam logic [7:0] DEF_MASK_ID = 8'h20;
  localparam logic [7:0] DEF_ACK_ID  = 8'h21;
  localparam logic [7:0] DEF_STAT_ID = 8'h22;
  localparam logic [7:0] DEF_VEC_ID  = 8'h23;
  localparam int unsigned DEF_HOLDOFF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // One MCU write-bus beat as seen on the I/O port.
  typedef struct packed {
    logic       strb;
    logic [7:0] port;
    logic [7:0] data;
  } io_wr_t;

endpackage

// File: rtl/rat_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, bit 0 wins.
module rat_prio_enc
  import rat_int_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    // Scan high-to-low so the last hit written is the lowest index.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// Eight-source edge-triggered interrupt controller for a small MCU I/O bus,
// with mask/pending/vector registers and a post-acknowledge INT holdoff.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter logic [7:0]  MASK_ID = DEF_MASK_ID,
  parameter logic [7:0]  ACK_ID  = DEF_ACK_ID,
  parameter logic [7:0]  STAT_ID = DEF_STAT_ID,
  parameter logic [7:0]  VEC_ID  = DEF_VEC_ID,
  parameter int unsigned HOLDOFF = DEF_HOLDOFF
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] IRQ,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic       INT_CU,
  output logic [7:0] RD_DATA,
  output logic       RD_HIT
);

  localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (HOLDOFF > 1) ? CNT_W'(HOLDOFF - 1) : '0;

  state_e             state_q, state_d;
  logic               int_q, int_d;
  logic [7:0]         pend_q, pend_d;
  logic [7:0]         mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         irq_q, irq_d;
  logic               armed_q, armed_d;

  io_wr_t             wr_c;
  logic               mask_wr_c;
  logic               ack_wr_c;
  logic [7:0]         rise_c;
  logic [7:0]         clr_c;
  logic [7:0]         req_c;
  logic [ID_W-1:0]    enc_idx_c;
  logic               enc_vld_c;

  assign wr_c      = '{strb: IO_STRB, port: PORT_ID, data: OUT_PORT};
  assign mask_wr_c = wr_c.strb && (wr_c.port == MASK_ID);
  assign ack_wr_c  = wr_c.strb && (wr_c.port == ACK_ID);
  // The first edge after reset only primes irq_q, so a source already high is not an edge.
  assign rise_c    = armed_q ? (IRQ & ~irq_q) : 8'h00;
  assign req_c     = pend_q & mask_q;

  rat_prio_enc u_prio_enc (
    .req (req_c),
    .idx (enc_idx_c),
    .vld (enc_vld_c)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      int_q   <= 1'b0;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      id_q    <= '0;
      cnt_q   <= '0;
      irq_q   <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    clr_c   = 8'h00;
    irq_d   = IRQ;
    armed_d = 1'b1;

    if (mask_wr_c) mask_d = wr_c.data;

    case (state_q)
      ST_IDLE: begin
        if (enc_vld_c) begin
          id_d    = enc_idx_c;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ack_wr_c) begin
          clr_c[id_q] = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ST_HOLD;
        end else if (!mask_q[id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Leave one cycle early: the IDLE cycle itself is the last INT-low cycle.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge on the acknowledged source survives its own clear.
    pend_d = (pend_q & ~clr_c) | rise_c;
    int_d  = (state_d == ST_ACTIVE);
  end

  assign INT_CU = int_q;

  always_comb begin
    RD_DATA = 8'h00;
    RD_HIT  = 1'b0;
    if (PORT_ID == MASK_ID) begin
      RD_DATA = mask_q;
      RD_HIT  = 1'b1;
    end else if (PORT_ID == STAT_ID) begin
      RD_DATA = pend_q;
      RD_HIT  = 1'b1;
    end else if (PORT_ID == VEC_ID) begin
      RD_DATA = {5'b00000, id_q};
      RD_HIT  = 1'b1;
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the controller.
module tb_rat_int_ctrl;

  localparam logic [7:0] A_MASK = 8'h20;
  localparam logic [7:0] A_ACK  = 8'h21;
  localparam logic [7:0] A_STAT = 8'h22;
  localparam logic [7:0] A_VEC  = 8'h23;
  localparam int         HOLD_N = 2;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] IRQ;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       INT_CU;
  logic [7:0] RD_DATA;
  logic       RD_HIT;

  int checks;
  int errors;

  // Behavioural model state
  logic [7:0] m_pend, m_mask, m_prev;
  logic       m_armed, m_active;
  logic [2:0] m_id;
  int         m_block;

  rat_int_ctrl dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IRQ      (IRQ),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .INT_CU   (INT_CU),
    .RD_DATA  (RD_DATA),
    .RD_HIT   (RD_HIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    PORT_ID  = a;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    IO_STRB = 1'b0;
    PORT_ID = a;
    #1;
    d = RD_DATA;
  endtask

  task automatic apply_reset();
    RESET_N  = 1'b0;
    IRQ      = 8'h00;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    apply_reset();
    checks++;
    if (INT_CU !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", INT_CU); end
    rd(A_MASK, d);
    checks++;
    if (d !== 8'h00 || RD_HIT !== 1'b1) begin errors++; $display("FAIL reset_mask got %h/%b exp 00/1", d, RD_HIT); end
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_stat got %h exp 00", d); end
    rd(A_ACK, d);
    checks++;
    if (d !== 8'h00 || RD_HIT !== 1'b0) begin errors++; $display("FAIL ack_not_readable got %h/%b exp 00/0", d, RD_HIT); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    apply_reset();
    wr(A_MASK, 8'h04);
    IRQ = 8'h04;
    tick();
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h04 || INT_CU !== 1'b0) begin errors++; $display("FAIL basic_pending got %h int %b exp 04 int 0", d, INT_CU); end
    tick();
    IRQ = 8'h00;
    checks++;
    if (INT_CU !== 1'b1) begin errors++; $display("FAIL basic_int_rise got %b exp 1", INT_CU); end
    rd(A_VEC, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL basic_vec got %h exp 02", d); end
    wr(A_ACK, 8'h5A);
    repeat (3) tick();
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h00 || INT_CU !== 1'b0) begin errors++; $display("FAIL basic_after_ack got %h int %b exp 00 int 0", d, INT_CU); end
    // Ack while idle must change nothing.
    wr(A_ACK, 8'h00);
    wr(A_STAT, 8'hFF);
    wr(A_VEC, 8'hFF);
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h00 || INT_CU !== 1'b0) begin errors++; $display("FAIL ro_regs got %h int %b exp 00 int 0", d, INT_CU); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    int lows;
    apply_reset();
    wr(A_MASK, 8'hFF);
    IRQ = 8'h22;
    tick();
    tick();
    IRQ = 8'h00;
    rd(A_VEC, d);
    checks++;
    if (d !== 8'h01 || INT_CU !== 1'b1) begin errors++; $display("FAIL prio_first got vec %h int %b exp 01 int 1", d, INT_CU); end
    wr(A_ACK, 8'h00);
    lows = 0;
    while (INT_CU === 1'b0 && lows < 10) begin lows++; tick(); end
    checks++;
    if (lows != HOLD_N) begin errors++; $display("FAIL prio_holdoff got %0d low cycles exp %0d", lows, HOLD_N); end
    rd(A_VEC, d);
    checks++;
    if (d !== 8'h05 || INT_CU !== 1'b1) begin errors++; $display("FAIL prio_second got vec %h int %b exp 05 int 1", d, INT_CU); end
  endtask

  task automatic test_masked();
    logic [7:0] d;
    apply_reset();
    IRQ = 8'h08;
    tick();
    IRQ = 8'h00;
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL masked_stat got %h exp 08", d); end
    repeat (3) tick();
    checks++;
    if (INT_CU !== 1'b0) begin errors++; $display("FAIL masked_int got %b exp 0", INT_CU); end
    wr(A_MASK, 8'h08);
    tick();
    rd(A_VEC, d);
    checks++;
    if (INT_CU !== 1'b1 || d !== 8'h03) begin errors++; $display("FAIL unmask_rise got int %b vec %h exp 1 03", INT_CU, d); end
  endtask

  task automatic test_unmask_drop();
    logic [7:0] d;
    int n;
    apply_reset();
    wr(A_MASK, 8'h01);
    IRQ = 8'h01;
    tick();
    tick();
    IRQ = 8'h00;
    checks++;
    if (INT_CU !== 1'b1) begin errors++; $display("FAIL drop_active got %b exp 1", INT_CU); end
    wr(A_MASK, 8'h00);
    n = 0;
    while (INT_CU === 1'b1 && n < 4) begin n++; tick(); end
    rd(A_STAT, d);
    checks++;
    if (INT_CU !== 1'b0 || d[0] !== 1'b1) begin errors++; $display("FAIL drop_retain got int %b stat %h exp 0 and bit0 set", INT_CU, d); end
  endtask

  task automatic test_ack_coincide();
    logic [7:0] d;
    int lows;
    apply_reset();
    wr(A_MASK, 8'hFF);
    IRQ = 8'h10;
    tick();
    tick();
    IRQ = 8'h00;
    tick();
    IRQ = 8'h10;
    wr(A_ACK, 8'h00);
    IRQ = 8'h00;
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h10 || INT_CU !== 1'b0) begin errors++; $display("FAIL coincide_pend got %h int %b exp 10 int 0", d, INT_CU); end
    lows = 0;
    while (INT_CU === 1'b0 && lows < 10) begin lows++; tick(); end
    rd(A_VEC, d);
    checks++;
    if (lows != HOLD_N || d !== 8'h04) begin errors++; $display("FAIL coincide_rearm got lows %0d vec %h exp %0d 04", lows, d, HOLD_N); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    apply_reset();
    wr(A_MASK, 8'hFF);
    IRQ = 8'h40;
    tick();
    tick();
    checks++;
    if (INT_CU !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", INT_CU); end
    IRQ = 8'h80;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (INT_CU !== 1'b0) begin errors++; $display("FAIL areset_async got %b exp 0", INT_CU); end
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    repeat (3) tick();
    rd(A_STAT, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL areset_stat got %h exp 00", d); end
    rd(A_MASK, d);
    checks++;
    if (d !== 8'h00 || INT_CU !== 1'b0) begin errors++; $display("FAIL areset_mask got %h int %b exp 00 int 0", d, INT_CU); end
    IRQ = 8'h00;
  endtask

  // One clock edge of the controller, described as rules on the pre-edge inputs.
  task automatic model_step();
    logic [7:0] rise;
    logic       ack, mwr;
    logic       found;
    ack  = IO_STRB && (PORT_ID == A_ACK);
    mwr  = IO_STRB && (PORT_ID == A_MASK);
    rise = m_armed ? (IRQ & ~m_prev) : 8'h00;
    if (m_active) begin
      if (ack) begin
        m_pend[m_id] = 1'b0;
        m_active     = 1'b0;
        m_block      = HOLD_N - 1;
      end else if (!m_mask[m_id]) begin
        m_active = 1'b0;
      end
    end else if (m_block > 0) begin
      m_block--;
    end else if ((m_pend & m_mask) != 8'h00) begin
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!found && m_pend[i] && m_mask[i]) begin
          m_id  = 3'(i);
          found = 1'b1;
        end
      end
      m_active = 1'b1;
    end
    m_pend  = m_pend | rise;
    if (mwr) m_mask = OUT_PORT;
    m_prev  = IRQ;
    m_armed = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] a, exp_d;
    logic       exp_hit;
    int         op;
    apply_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
    m_armed = 1'b1; m_active = 1'b0; m_id = 3'd0; m_block = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      IRQ = IRQ ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      op  = int'($urandom_range(0, 9));
      IO_STRB  = 1'b0;
      PORT_ID  = 8'($urandom);
      OUT_PORT = 8'($urandom);
      if (op <= 1) begin IO_STRB = 1'b1; PORT_ID = A_MASK; end
      else if (op <= 4) begin IO_STRB = 1'b1; PORT_ID = A_ACK; end
      else if (op == 5) begin IO_STRB = 1'b1; PORT_ID = A_STAT; end
      else if (op == 6) begin IO_STRB = 1'b1; PORT_ID = A_VEC; end
      model_step();
      tick();
      IO_STRB = 1'b0;
      checks++;
      if (INT_CU !== m_active) begin errors++; $display("FAIL rand_int cyc %0d got %b exp %b", cyc, INT_CU, m_active); end
      case ($urandom_range(0, 4))
        0: a = A_MASK;
        1: a = A_STAT;
        2: a = A_VEC;
        3: a = A_ACK;
        default: a = 8'($urandom);
      endcase
      exp_d = 8'h00;
      exp_hit = 1'b0;
      if (a == A_MASK) begin exp_d = m_mask; exp_hit = 1'b1; end
      else if (a == A_STAT) begin exp_d = m_pend; exp_hit = 1'b1; end
      else if (a == A_VEC) begin exp_d = {5'b00000, m_id}; exp_hit = 1'b1; end
      PORT_ID = a;
      #1;
      checks++;
      if (RD_DATA !== exp_d || RD_HIT !== exp_hit) begin
        errors++;
        $display("FAIL rand_read cyc %0d port %h got %h/%b exp %h/%b", cyc, a, RD_DATA, RD_HIT, exp_d, exp_hit);
      end
    end
    IRQ = 8'h00;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RESET_N  = 1'b0;
    IRQ      = 8'h00;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_masked();
    test_unmask_drop();
    test_ack_coincide();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
